// File: rtl/cnt_arb_if.sv
// Request, shared bit-count datapath and response signals of the cnt_arb arbiter.
// slave = arbiter side, master = requesters/datapath/consumer side.
interface cnt_arb_if #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       ReqValid;
  logic [NREQ-1:0]       ReqReady;
  logic [NREQ*WIDTH-1:0] ReqA;
  logic [2*NREQ-1:0]     ReqOp;
  logic [NREQ-1:0]       ReqW64;
  logic [WIDTH-1:0]      DpA;
  logic [WIDTH-1:0]      DpRevA;
  logic [4:0]            DpB;
  logic                  DpW64;
  logic [WIDTH-1:0]      DpResult;
  logic                  RspValid;
  logic                  RspReady;
  logic [IDW-1:0]        RspId;
  logic [WIDTH-1:0]      RspResult;

  modport slave (
    input  ReqValid, ReqA, ReqOp, ReqW64, DpResult, RspReady,
    output ReqReady, DpA, DpRevA, DpB, DpW64, RspValid, RspId, RspResult
  );

  modport master (
    output ReqValid, ReqA, ReqOp, ReqW64, DpResult, RspReady,
    input  ReqReady, DpA, DpRevA, DpB, DpW64, RspValid, RspId, RspResult
  );
endinterface

// File: rtl/cnt_arb.sv
// Round-robin arbiter sharing one clz/ctz/cpop datapath among NREQ requesters,
// with a one-entry registered response stage tagged by requester id.
module cnt_arb #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 2
) (
  input logic       clk,
  input logic       resetn,
  cnt_arb_if.slave  bus
);
  localparam int             IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW:0]   NREQ_X = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ-1);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] sel;
  logic [IDW:0]   idx;
  logic           free;
  logic           found;
  logic           gnt;

  // Scan Ptr, Ptr+1, ... modulo NREQ; sel stays at Ptr when nothing is valid.
  always_comb begin
    free  = !bus.RspValid || bus.RspReady;
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= NREQ_X) idx = idx - NREQ_X;
      if (!found && bus.ReqValid[idx[IDW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
    gnt = free && found;
  end

  always_comb begin
    bus.ReqReady = '0;
    if (gnt) bus.ReqReady[sel] = 1'b1;
  end

  assign bus.DpA   = bus.ReqA[int'(sel)*WIDTH +: WIDTH];
  assign bus.DpB   = {3'b000, bus.ReqOp[int'(sel)*2 +: 2]};
  assign bus.DpW64 = (WIDTH == 64) ? bus.ReqW64[sel] : 1'b0;

  for (genvar k = 0; k < WIDTH; k++) begin : g_rev
    assign bus.DpRevA[k] = bus.DpA[WIDTH-1-k];
  end

  // A grant always wins over a plain drain, giving back-to-back responses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr           <= '0;
      bus.RspValid  <= 1'b0;
      bus.RspId     <= '0;
      bus.RspResult <= '0;
    end else if (gnt) begin
      bus.RspValid  <= 1'b1;
      bus.RspId     <= sel;
      bus.RspResult <= bus.DpResult;
      ptr           <= (sel == LAST) ? '0 : sel + 1'b1;
    end else if (bus.RspReady) begin
      bus.RspValid  <= 1'b0;
    end
  end
endmodule
